// File: rtl/pe_ctrl_pkg.sv
// Shared definitions between the PE main controller and its host-side command sequencer:
// sequencer state encoding, pass function codes and PE mode encodings.
package pe_ctrl_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_SETTLE    = 3'd2;
    localparam logic [2:0] ST_WAIT_CMD  = 3'd3;
    localparam logic [2:0] ST_ISSUE     = 3'd4;
    localparam logic [2:0] ST_FEED      = 3'd5;
    localparam logic [2:0] ST_WAIT_DONE = 3'd6;
    localparam logic [2:0] ST_NEXT      = 3'd7;

    typedef enum logic [2:0] {
        StIdle     = ST_IDLE,
        StStart    = ST_START,
        StSettle   = ST_SETTLE,
        StWaitCmd  = ST_WAIT_CMD,
        StIssue    = ST_ISSUE,
        StFeed     = ST_FEED,
        StWaitDone = ST_WAIT_DONE,
        StNext     = ST_NEXT
    } seq_state_e;

    localparam logic FUNC_CONV = 1'b0;
    localparam logic FUNC_PSUM = 1'b1;

    localparam logic [1:0] MODE_0 = 2'd0;
    localparam logic [1:0] MODE_1 = 2'd1;
    localparam logic [1:0] MODE_2 = 2'd2;

endpackage

// File: rtl/pe_psum_feeder.sv
// Streams external partial sums into the PE psum input buffer, counting writes until a
// full accumulate pass worth of words has been pushed.
module pe_psum_feeder #(
    parameter int unsigned PSUM_WORDS = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic active,
    input  logic src_valid,
    input  logic psum_buf_full,
    output logic src_ready,
    output logic wen,
    output logic done
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        src_ready = active & ~psum_buf_full;
        wen       = active & src_valid & ~psum_buf_full;
        // done fires on the write that completes the pass, so FEED leaves with no idle cycle
        done      = wen && (cnt_q == CNT_WIDTH'(PSUM_WORDS - 1));
        cnt_d     = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (wen) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pe_cmd_sequencer.sv
// Host-side driver for the PE main controller: replays accepted pass commands onto the PE
// start/change_mode handshake, feeds psums for accumulate passes and watches for hangs.
module pe_cmd_sequencer
    import pe_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned PSUM_WORDS  = 4,
    parameter int unsigned CNT_WIDTH   = 8,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_func,
    input  logic [1:0]            cmd_mode,
    input  logic                  cmd_last,
    output logic                  pe_start,
    output logic                  pe_change_mode,
    output logic                  pe_func,
    output logic [1:0]            pe_mode,
    input  logic                  pe_done,
    input  logic                  pe_sum_done,
    input  logic                  src_valid,
    output logic                  src_ready,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  psum_buf_wen,
    output logic [DATA_WIDTH-1:0] psum_buf_wdata,
    input  logic                  psum_buf_full,
    output logic                  busy,
    output logic                  seq_done,
    output logic                  wdog_err,
    output logic [CNT_WIDTH-1:0]  pass_cnt
);

    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

    seq_state_e           state_q, state_d;
    logic                 settle_q, settle_d;
    logic                 func_q, func_d;
    logic [1:0]           mode_q, mode_d;
    logic                 last_q, last_d;
    logic                 done_seen_q, done_seen_d;
    logic [CNT_WIDTH-1:0] pass_cnt_q, pass_cnt_d;
    logic [WDOG_W-1:0]    wdog_cnt_q, wdog_cnt_d;
    logic                 wdog_err_q, wdog_err_d;

    logic feed_start;
    logic feed_active;
    logic feed_done;

    pe_psum_feeder #(
        .PSUM_WORDS (PSUM_WORDS),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_feeder (
        .clk           (clk),
        .rst           (rst),
        .start         (feed_start),
        .active        (feed_active),
        .src_valid     (src_valid),
        .psum_buf_full (psum_buf_full),
        .src_ready     (src_ready),
        .wen           (psum_buf_wen),
        .done          (feed_done)
    );

    always_comb begin
        state_d        = state_q;
        settle_d       = settle_q;
        func_d         = func_q;
        mode_d         = mode_q;
        last_d         = last_q;
        done_seen_d    = done_seen_q;
        pass_cnt_d     = pass_cnt_q;
        wdog_cnt_d     = wdog_cnt_q;
        wdog_err_d     = wdog_err_q;
        cmd_ready      = 1'b0;
        pe_start       = 1'b0;
        pe_change_mode = 1'b0;
        seq_done       = 1'b0;
        feed_start     = 1'b0;
        feed_active    = 1'b0;

        unique case (state_q)
            StIdle: begin
                done_seen_d = 1'b0;
                if (cmd_valid) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                pe_start = 1'b1;
                settle_d = 1'b0;
                state_d  = StSettle;
            end
            StSettle: begin
                // two cycles for the PE to drop out of start-hold into command-wait
                if (settle_q) begin
                    state_d = StWaitCmd;
                end else begin
                    settle_d = 1'b1;
                end
            end
            StWaitCmd: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    func_d  = cmd_func;
                    mode_d  = cmd_mode;
                    last_d  = cmd_last;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                pe_change_mode = 1'b1;
                feed_start     = 1'b1;
                done_seen_d    = 1'b0;
                wdog_cnt_d     = WDOG_W'(1);
                state_d        = (func_q == FUNC_PSUM) ? StFeed : StWaitDone;
            end
            StFeed: begin
                feed_active = 1'b1;
                if (pe_sum_done) begin
                    done_seen_d = 1'b1;
                end
                if (feed_done) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (func_q == FUNC_CONV) begin
                    if (pe_done) begin
                        state_d = StNext;
                    end
                end else if (pe_sum_done || done_seen_q) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                pass_cnt_d  = pass_cnt_q + CNT_WIDTH'(1);
                done_seen_d = 1'b0;
                if (last_q) begin
                    seq_done = 1'b1;
                    state_d  = StIdle;
                end else begin
                    state_d = StWaitCmd;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A pass that completes on the very cycle the watchdog expires is still counted.
        if (state_q == StFeed || state_q == StWaitDone) begin
            wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
            if (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1) && state_d != StNext) begin
                wdog_err_d = 1'b1;
                state_d    = StIdle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            settle_q    <= 1'b0;
            func_q      <= 1'b0;
            mode_q      <= 2'd0;
            last_q      <= 1'b0;
            done_seen_q <= 1'b0;
            pass_cnt_q  <= '0;
            wdog_cnt_q  <= '0;
            wdog_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            func_q      <= func_d;
            mode_q      <= mode_d;
            last_q      <= last_d;
            done_seen_q <= done_seen_d;
            pass_cnt_q  <= pass_cnt_d;
            wdog_cnt_q  <= wdog_cnt_d;
            wdog_err_q  <= wdog_err_d;
        end
    end

    assign pe_func        = func_q;
    assign pe_mode        = mode_q;
    assign busy           = (state_q != StIdle);
    assign wdog_err       = wdog_err_q;
    assign pass_cnt       = pass_cnt_q;
    assign psum_buf_wdata = src_data;

endmodule

// File: tb/tb_pe_cmd_sequencer.sv
// Directed bench for pe_cmd_sequencer: a table of passes plus hand-written reset,
// watchdog and pass-counter wrap sequences.
module tb_pe_cmd_sequencer;
    import pe_ctrl_pkg::*;

    localparam int PSUM_WORDS = 4;

    typedef struct {
        bit         rst_before;
        bit         first;
        bit         func;
        logic [1:0] mode;
        bit         last;
        int         delay;
        bit         wrong;
        int         full_lo;
        int         full_hi;
        int         sd_feed;
        int         base_word;
        int         exp_feed;
        int         exp_pass;
    } pass_vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_func, cmd_last;
    logic [1:0]  cmd_mode;
    logic        pe_done, pe_sum_done, src_valid, psum_buf_full;
    logic [15:0] src_data;

    logic        cmd_ready, pe_start, pe_change_mode, pe_func;
    logic [1:0]  pe_mode;
    logic        src_ready, psum_buf_wen, busy, seq_done, wdog_err;
    logic [15:0] psum_buf_wdata;
    logic [7:0]  pass_cnt;

    logic        wd_cmd_ready, wd_pe_start, wd_pe_change_mode, wd_pe_func;
    logic [1:0]  wd_pe_mode;
    logic        wd_src_ready, wd_psum_buf_wen, wd_busy, wd_seq_done, wd_wdog_err;
    logic [15:0] wd_psum_buf_wdata;
    logic [7:0]  wd_pass_cnt;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_wen = 0;
    int src_idx = 0;
    int done_cyc = 0;
    logic cm_prev = 1'b0;
    logic hs, wen_now;
    logic [15:0] last_wdata;

    always #5 clk = ~clk;

    pe_cmd_sequencer #(
        .DATA_WIDTH(16), .PSUM_WORDS(PSUM_WORDS), .CNT_WIDTH(8), .WDOG_CYCLES(1024)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_func(cmd_func), .cmd_mode(cmd_mode), .cmd_last(cmd_last),
        .pe_start(pe_start), .pe_change_mode(pe_change_mode), .pe_func(pe_func),
        .pe_mode(pe_mode), .pe_done(pe_done), .pe_sum_done(pe_sum_done),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .psum_buf_wen(psum_buf_wen), .psum_buf_wdata(psum_buf_wdata),
        .psum_buf_full(psum_buf_full), .busy(busy), .seq_done(seq_done),
        .wdog_err(wdog_err), .pass_cnt(pass_cnt)
    );

    pe_cmd_sequencer #(
        .DATA_WIDTH(16), .PSUM_WORDS(PSUM_WORDS), .CNT_WIDTH(8), .WDOG_CYCLES(16)
    ) dut_wd (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(wd_cmd_ready),
        .cmd_func(cmd_func), .cmd_mode(cmd_mode), .cmd_last(cmd_last),
        .pe_start(wd_pe_start), .pe_change_mode(wd_pe_change_mode), .pe_func(wd_pe_func),
        .pe_mode(wd_pe_mode), .pe_done(pe_done), .pe_sum_done(pe_sum_done),
        .src_valid(src_valid), .src_ready(wd_src_ready), .src_data(src_data),
        .psum_buf_wen(wd_psum_buf_wen), .psum_buf_wdata(wd_psum_buf_wdata),
        .psum_buf_full(psum_buf_full), .busy(wd_busy), .seq_done(wd_seq_done),
        .wdog_err(wd_wdog_err), .pass_cnt(wd_pass_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Sample outputs at the falling edge, then advance to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (pe_change_mode) check("cm_not_back_to_back", {31'd0, cm_prev}, 0);
        cm_prev = pe_change_mode;
        if (src_valid) check("wen_vs_ready", {31'd0, psum_buf_wen}, {31'd0, src_ready});
        hs = src_valid & src_ready;
        wen_now = psum_buf_wen;
        if (psum_buf_wen) begin
            n_wen++;
            last_wdata = psum_buf_wdata;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (hs) src_idx++;
    endtask

    task automatic clear_inputs();
        cmd_valid = 0; cmd_func = 0; cmd_mode = 0; cmd_last = 0;
        pe_done = 0; pe_sum_done = 0; src_valid = 0; src_data = 0; psum_buf_full = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    function automatic pass_vec_t mk(input bit rb, input bit fi, input bit fn,
                                     input logic [1:0] m, input bit l, input int dl,
                                     input bit wr, input int flo, input int fhi, input int sd,
                                     input int bw, input int ef, input int ep);
        pass_vec_t v;
        v.rst_before = rb; v.first = fi; v.func = fn; v.mode = m; v.last = l;
        v.delay = dl; v.wrong = wr; v.full_lo = flo; v.full_hi = fhi; v.sd_feed = sd;
        v.base_word = bw; v.exp_feed = ef; v.exp_pass = ep;
        return v;
    endfunction

    task automatic run_pass(input pass_vec_t v);
        int base;
        int feed_k;
        int d_cyc;
        if (v.rst_before) do_reset();
        cmd_func = v.func; cmd_mode = v.mode; cmd_last = v.last; cmd_valid = 1;
        if (v.first) begin
            check("idle_busy", {31'd0, busy}, 0);
            tick();
            check("start_pulse", {31'd0, pe_start}, 1);
            tick();
            check("start_one_cycle", {31'd0, pe_start}, 0);
            tick();
            check("settle_not_ready", {31'd0, cmd_ready}, 0);
            tick();
        end
        check("wait_cmd_ready", {31'd0, cmd_ready}, 1);
        tick();
        cmd_valid = 0;
        check("change_mode", {31'd0, pe_change_mode}, 1);
        check("pe_func", {31'd0, pe_func}, {31'd0, v.func});
        check("pe_mode", {30'd0, pe_mode}, {30'd0, v.mode});
        if (!v.first) check("cm_gap", cyc - done_cyc, 3);
        tick();
        if (v.func) begin
            base = n_wen;
            src_idx = 0;
            feed_k = 1;
            while (n_wen - base < PSUM_WORDS && feed_k <= 40) begin
                psum_buf_full = (feed_k >= v.full_lo && feed_k <= v.full_hi);
                pe_sum_done = (feed_k == v.sd_feed);
                src_valid = (src_idx < PSUM_WORDS);
                src_data = 16'(v.base_word + src_idx);
                tick();
                if (wen_now) check("wdata", {16'd0, last_wdata}, v.base_word + n_wen - base - 1);
                feed_k++;
            end
            src_valid = 0; psum_buf_full = 0; pe_sum_done = 0;
            check("feed_words", n_wen - base, PSUM_WORDS);
            check("feed_cycles", feed_k - 1, v.exp_feed);
        end
        if (v.sd_feed != 0) begin
            d_cyc = cyc;
        end else begin
            for (int k = 1; k < v.delay; k++) begin
                if (v.wrong && k == 1) begin
                    if (v.func) pe_done = 1; else pe_sum_done = 1;
                end
                tick();
                pe_done = 0; pe_sum_done = 0;
            end
            if (v.func) pe_sum_done = 1; else pe_done = 1;
            d_cyc = cyc;
        end
        tick();
        pe_done = 0; pe_sum_done = 0;
        check("seq_done", {31'd0, seq_done}, {31'd0, v.last});
        check("next_busy", {31'd0, busy}, 1);
        tick();
        check("pass_cnt", {24'd0, pass_cnt}, v.exp_pass);
        check("busy_after", {31'd0, busy}, {31'd0, !v.last});
        check("seq_done_one_cycle", {31'd0, seq_done}, 0);
        done_cyc = d_cyc;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        pass_vec_t vecs[6];
        vecs[0] = mk(0, 1, FUNC_CONV, MODE_2, 1, 20, 0, 0, -1, 0, 0,     0, 1);
        vecs[1] = mk(0, 1, FUNC_PSUM, MODE_1, 1,  3, 0, 2,  5, 0, 'hA1, 8, 2);
        vecs[2] = mk(1, 1, FUNC_CONV, MODE_0, 0,  5, 1, 0, -1, 0, 0,     0, 1);
        vecs[3] = mk(0, 0, FUNC_PSUM, MODE_1, 0,  2, 0, 0, -1, 0, 'hB1, 4, 2);
        vecs[4] = mk(0, 0, FUNC_CONV, MODE_2, 1,  4, 0, 0, -1, 0, 0,     0, 3);
        vecs[5] = mk(0, 1, FUNC_PSUM, MODE_2, 1,  6, 0, 0, -1, 2, 'hC1, 4, 4);

        rst = 1;
        clear_inputs();
        do_reset();
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 0);
        check("rst_pe_start", {31'd0, pe_start}, 0);
        check("rst_change_mode", {31'd0, pe_change_mode}, 0);
        check("rst_pe_func", {31'd0, pe_func}, 0);
        check("rst_pe_mode", {30'd0, pe_mode}, 0);
        check("rst_wen", {31'd0, psum_buf_wen}, 0);
        check("rst_src_ready", {31'd0, src_ready}, 0);
        check("rst_seq_done", {31'd0, seq_done}, 0);
        check("rst_wdog_err", {31'd0, wdog_err}, 0);
        check("rst_pass_cnt", {24'd0, pass_cnt}, 0);

        for (int i = 0; i < 6; i++) run_pass(vecs[i]);

        // Reset in the middle of FEED.
        cmd_func = FUNC_PSUM; cmd_mode = MODE_0; cmd_last = 1; cmd_valid = 1;
        repeat (4) tick();
        tick();
        cmd_valid = 0;
        check("rstfeed_cm", {31'd0, pe_change_mode}, 1);
        tick();
        src_valid = 1; src_data = 16'h00D1;
        tick();
        check("rstfeed_wen_before", {31'd0, psum_buf_wen}, 1);
        check("rstfeed_pass_before", {24'd0, pass_cnt}, 4);
        rst = 1;
        tick();
        check("rstfeed_wen", {31'd0, psum_buf_wen}, 0);
        check("rstfeed_busy", {31'd0, busy}, 0);
        check("rstfeed_pass_cnt", {24'd0, pass_cnt}, 0);
        check("rstfeed_wdog_err", {31'd0, wdog_err}, 0);
        rst = 0;
        src_valid = 0;

        // Watchdog with no completion pulse (second instance, 16-cycle limit).
        do_reset();
        cmd_func = FUNC_CONV; cmd_mode = MODE_1; cmd_last = 1; cmd_valid = 1;
        repeat (4) tick();
        tick();
        cmd_valid = 0;
        check("wd_change_mode", {31'd0, wd_pe_change_mode}, 1);
        repeat (15) tick();
        check("wd_err_early", {31'd0, wd_wdog_err}, 0);
        check("wd_busy_early", {31'd0, wd_busy}, 1);
        tick();
        check("wd_err", {31'd0, wd_wdog_err}, 1);
        check("wd_idle", {31'd0, wd_busy}, 0);
        check("wd_mode_held", {30'd0, wd_pe_mode}, {30'd0, MODE_1});
        repeat (3) tick();
        check("wd_err_sticky", {31'd0, wd_wdog_err}, 1);
        check("main_no_wdog", {31'd0, wdog_err}, 0);
        check("main_still_busy", {31'd0, busy}, 1);
        do_reset();
        check("wd_err_cleared", {31'd0, wd_wdog_err}, 0);

        // pass_cnt wraps after 256 passes in one long sequence.
        for (int n = 0; n < 256; n++) begin
            run_pass(mk(0, n == 0, FUNC_CONV, 2'(n % 3), n == 255, 1, 0, 0, -1, 0, 0, 0,
                        (n + 1) % 256));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
